// File: rtl/data_sram_resp.sv
// Data-SRAM responder: registered-read word memory with byte write enables and a post-reset zero-fill FSM.
// Optional access counters rd_cnt/wr_cnt are built when DATA_SRAM_STATS_EN is defined.
module data_sram_resp #(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq_mem,
  output logic        mem_ready
`ifdef DATA_SRAM_STATS_EN
  ,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
`endif
);

  localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTES  = DATA_W / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = '1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam state_e RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clear_ptr_q, clear_ptr_d;
  logic [DATA_W-1:0]       rdata_q, rdata_d;
  logic                    stall_q, stall_d;
  logic                    ready_q, ready_d;

  logic [DATA_W-1:0]       mem_q [DEPTH];

  logic                    mem_we_c;
  logic [BYTES-1:0]        mem_be_c;
  logic [ADDR_WIDTH-1:0]   mem_idx_c;
  logic [DATA_W-1:0]       mem_wdata_c;
  logic [ADDR_WIDTH-1:0]   word_idx_c;
  logic                    rd_c;
  logic                    wr_c;

  // Byte-offset bits and bits above the index are intentionally dropped (aliasing).
  logic unused_addr_c;
  assign word_idx_c    = data_sram_addr[ADDR_WIDTH+1:2];
  assign unused_addr_c = ^{data_sram_addr[31:ADDR_WIDTH+2], data_sram_addr[1:0]};

  // Next-state, array-port and read-data logic.
  always_comb begin
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    rdata_d     = rdata_q;
    mem_we_c    = 1'b0;
    mem_be_c    = '0;
    mem_idx_c   = word_idx_c;
    mem_wdata_c = data_sram_wdata;
    rd_c        = 1'b0;
    wr_c        = 1'b0;

    case (state_q)
      ST_CLEAR: begin
        mem_we_c    = 1'b1;
        mem_be_c    = '1;
        mem_idx_c   = clear_ptr_q;
        mem_wdata_c = '0;
        clear_ptr_d = clear_ptr_q + ADDR_WIDTH'(1);
        if (clear_ptr_q == LAST_PTR) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (data_sram_en) begin
          if (data_sram_wen == '0) begin
            rd_c    = 1'b1;
            rdata_d = mem_q[word_idx_c];
          end else begin
            wr_c     = 1'b1;
            mem_we_c = 1'b1;
            mem_be_c = data_sram_wen;
          end
        end
      end
      default: begin
        state_d = RST_STATE;
      end
    endcase

    stall_d = (state_d == ST_CLEAR);
    ready_d = (state_d == ST_READY);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RST_STATE;
      clear_ptr_q <= '0;
      rdata_q     <= '0;
      stall_q     <= (RST_STATE == ST_CLEAR);
      ready_q     <= (RST_STATE == ST_READY);
    end else begin
      state_q     <= state_d;
      clear_ptr_q <= clear_ptr_d;
      rdata_q     <= rdata_d;
      stall_q     <= stall_d;
      ready_q     <= ready_d;
    end
  end

  // Storage array; no writes land while reset is held.
  always_ff @(posedge clk) begin
    if (!rst && mem_we_c) begin
      for (int b = 0; b < int'(BYTES); b++) begin
        if (mem_be_c[b]) begin
          mem_q[mem_idx_c][8*b +: 8] <= mem_wdata_c[8*b +: 8];
        end
      end
    end
  end

  assign data_sram_rdata = rdata_q;
  assign stallreq_mem    = stall_q;
  assign mem_ready       = ready_q;

`ifdef DATA_SRAM_STATS_EN
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (rd_c) begin
      rd_cnt_d = rd_cnt_q + 32'd1;
    end
    if (wr_c) begin
      wr_cnt_d = wr_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`else
  logic unused_cnt_c;
  assign unused_cnt_c = rd_c ^ wr_c;
`endif

endmodule

// File: tb/tb_data_sram_resp.sv
// Self-checking bench for data_sram_resp (ADDR_WIDTH=4, CLEAR_ON_RESET=1) with a behavioural memory model.
module tb_data_sram_resp;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        ready;
`ifdef DATA_SRAM_STATS_EN
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  always #5 clk = ~clk;

  data_sram_resp #(
    .ADDR_WIDTH    (AW),
    .CLEAR_ON_RESET(1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .data_sram_en   (en),
    .data_sram_wen  (wen),
    .data_sram_addr (addr),
    .data_sram_wdata(wdata),
    .data_sram_rdata(rdata),
    .stallreq_mem   (stall),
    .mem_ready      (ready)
`ifdef DATA_SRAM_STATS_EN
    ,
    .rd_cnt         (rd_cnt),
    .wr_cnt         (wr_cnt)
`endif
  );

  // Behavioural model: a countdown of remaining clear cycles plus a word array.
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_rdata;
  int          m_clear_left;
  logic [31:0] m_rd;
  logic [31:0] m_wr;

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_clear_left <= DEPTH;
      m_rdata      <= 32'h0;
      m_rd         <= 32'h0;
      m_wr         <= 32'h0;
    end else if (m_clear_left > 0) begin
      m_clear_left <= m_clear_left - 1;
      if (m_clear_left == 1) begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] <= 32'h0;
      end
    end else if (en) begin
      if (wen == 4'b0000) begin
        m_rdata <= m_mem[addr[AW+1:2]];
        m_rd    <= m_rd + 32'd1;
      end else begin
        m_mem[addr[AW+1:2]] <= merge(m_mem[addr[AW+1:2]], wdata, wen);
        m_wr                <= m_wr + 32'd1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("model_stallreq_mem", {31'b0, stall}, {31'b0, (m_clear_left != 0)});
      check("model_mem_ready", {31'b0, ready}, {31'b0, (m_clear_left == 0)});
      check("model_rdata", rdata, m_rdata);
`ifdef DATA_SRAM_STATS_EN
      check("model_rd_cnt", rd_cnt, m_rd);
      check("model_wr_cnt", wr_cnt, m_wr);
`endif
    end
  end

  task automatic drive(input logic e, input logic [3:0] w, input logic [31:0] a,
                       input logic [31:0] d);
    @(posedge clk);
    #1;
    en = e; wen = w; addr = a; wdata = d;
  endtask

  task automatic idle();
    drive(1'b0, 4'b0000, 32'h0, 32'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    drive(1'b1, w, a, d);
  endtask

  task automatic rd(input logic [31:0] a);
    drive(1'b1, 4'b0000, a, 32'h0);
  endtask

  task automatic read_expect(input logic [31:0] a, input logic [31:0] exp, input string name);
    rd(a);
    idle();
    check(name, rdata, exp);
  endtask

  // Counts cycles with stallreq_mem high from the current point; drops any held request after.
  task automatic wait_clear(input string name);
    int n;
    n = 0;
    while (stall === 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    en = 1'b0; wen = 4'b0000;
    check(name, 32'(n), 32'd16);
    check({name, "_ready"}, {31'b0, ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; wen = 4'b0000; addr = 32'h0; wdata = 32'h0;
    @(posedge clk);
    #1;
    chk_on = 1'b1;
    check("reset_rdata", rdata, 32'h0);
    check("reset_stall", {31'b0, stall}, 32'd1);
    check("reset_ready", {31'b0, ready}, 32'd0);
    @(posedge clk);
    #1;
    // Hold a write to word 1 for the whole clear; it must be ignored.
    rst = 1'b0; en = 1'b1; wen = 4'b1111; addr = 32'h4; wdata = 32'hFFFF_FFFF;
    wait_clear("clear_len_first");
`ifdef DATA_SRAM_STATS_EN
    check("cnt_rd_after_clear", rd_cnt, 32'd0);
    check("cnt_wr_after_clear", wr_cnt, 32'd0);
`endif
    for (int i = 0; i < DEPTH; i++) begin
      read_expect(32'(i * 4), 32'h0, "zero_fill");
    end

    wr(32'h8, 32'hDEAD_BEEF, 4'b1111);
    read_expect(32'h8, 32'hDEAD_BEEF, "wr_rd_full");
    wr(32'h8, 32'h1122_3344, 4'b0101);
    idle();
    check("rdata_hold_on_write", rdata, 32'hDEAD_BEEF);
    read_expect(32'h8, 32'hDE22_BE44, "byte_merge");

    wr(32'h40, 32'h1234_5678, 4'b1111);
    read_expect(32'h00, 32'h1234_5678, "alias_high_bits");
    read_expect(32'h43, 32'h1234_5678, "alias_low_bits");

    wr(32'h10, 32'hAABB_CCDD, 4'b1111);
    rd(32'h10);
    rd(32'h8);
    check("b2b_rd_after_wr", rdata, 32'hAABB_CCDD);
    idle();
    check("b2b_second_rd", rdata, 32'hDE22_BE44);
    idle();
    check("en0_hold", rdata, 32'hDE22_BE44);

    // Reset, then pulse reset again after 7 clear cycles.
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    check("mid_clear_stall", {31'b0, stall}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    check("restart_rdata", rdata, 32'h0);
    wait_clear("clear_len_restart");
    read_expect(32'h8, 32'h0, "recleared_word");

    // 3 reads, 2 writes, 1 idle (the preceding read adds one more read).
    rd(32'h0);
    rd(32'h4);
    wr(32'h8, 32'h0102_0304, 4'b1111);
    idle();
    wr(32'hC, 32'hA5A5_A5A5, 4'b0011);
    rd(32'h8);
    idle();
    check("stats_rd_data", rdata, 32'h0102_0304);
`ifdef DATA_SRAM_STATS_EN
    check("stats_rd_cnt", rd_cnt, 32'd4);
    check("stats_wr_cnt", wr_cnt, 32'd2);
`endif
    read_expect(32'hC, 32'h0000_A5A5, "partial_write_zero_base");
    idle();

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
